mem_access_unit: RTL

- Initiator side of the word-wide data-memory interface. Sits between the CPU execute stage and the data memory.
- Accepts one load/store request at a time and checks alignment and address range.
- Issues memory read/write strobes and performs read-modify-write for byte/halfword stores.
- Returns sign/zero-extended load data with a one-cycle response pulse.

---
 rtl/mem_access_unit_pkg.sv | 30 +++
 rtl/mem_access_unit_lane_align.sv | 58 +++++
 rtl/mem_access_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the data-memory access unit: request opcodes,
// FSM states and the default memory window.
package mem_access_unit_pkg;

    localparam logic [31:0] BASE_ADDR_DEF   = 32'h1001_0000;
    localparam int          DEPTH_WORDS_DEF = 2048;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic is_load(op_e op);
        return op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Little-endian lane handling: extract/extend load data from a memory word and
// merge byte/halfword store data into a previously read word.
module mem_access_unit_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  op_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);

    op_e         op;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign op = op_e'(op_i);

    always_comb begin
        case (addr_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];

        case (op)
            OP_LH:   load_o = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_o = {16'h0000, half_sel};
            OP_LB:   load_o = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_o = {24'h000000, byte_sel};
            default: load_o = word_i;
        endcase
    end

    always_comb begin
        store_o = word_i;
        case (op)
            OP_SW: store_o = wdata_i;
            OP_SH: begin
                if (addr_i[1]) store_o[31:16] = wdata_i[15:0];
                else           store_o[15:0]  = wdata_i[15:0];
            end
            OP_SB: begin
                case (addr_i)
                    2'd0:    store_o[7:0]   = wdata_i[7:0];
                    2'd1:    store_o[15:8]  = wdata_i[7:0];
                    2'd2:    store_o[23:16] = wdata_i[7:0];
                    default: store_o[31:24] = wdata_i[7:0];
                endcase
            end
            default: store_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the word-wide data-memory port: one load/store at a time,
// with alignment/range checking and read-modify-write for sub-word stores.
//
// state   | meaning
// IDLE    | ready for a request; error check at acceptance
// RD      | memory read strobe, word captured into word_q
// WR      | memory write strobe with full or merged word
// DONE    | one-cycle response from registered op/word/error
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
    parameter int          DEPTH_WORDS = DEPTH_WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        dm_ena,
    output logic        dm_r,
    output logic        dm_w,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    // 33-bit bound so a window ending at the top of the address space cannot wrap
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    op_e         req_op_e;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;
    logic        err_q, err_d;
    logic        misaligned, out_of_range;
    logic [31:0] load_data, store_word;

    assign req_op_e = op_e'(req_op);
    assign dm_addr  = {addr_q[31:2], 2'b00};

    always_comb begin
        case (req_op_e)
            OP_LW, OP_SW:          misaligned = (req_addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH:  misaligned = req_addr[0];
            default:               misaligned = 1'b0;
        endcase
        out_of_range = ({1'b0, req_addr} < {1'b0, BASE_ADDR}) ||
                       ({1'b0, req_addr} >= END_ADDR);
    end

    mem_access_unit_lane_align u_lane_align (
        .word_i  (word_q),
        .wdata_i (wdata_q),
        .addr_i  (addr_q[1:0]),
        .op_i    (op_q),
        .load_o  (load_data),
        .store_o (store_word)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        word_d     = word_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        resp_err   = 1'b0;
        dm_ena     = 1'b0;
        dm_r       = 1'b0;
        dm_w       = 1'b0;
        dm_wdata   = 32'h0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d    = req_op_e;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = misaligned | out_of_range;
                    if (misaligned | out_of_range) state_d = ST_DONE;
                    else if (req_op_e == OP_SW)    state_d = ST_WR;
                    else                           state_d = ST_RD;
                end
            end
            ST_RD: begin
                dm_ena  = 1'b1;
                dm_r    = 1'b1;
                word_d  = dm_rdata;
                state_d = is_load(op_q) ? ST_DONE : ST_WR;
            end
            ST_WR: begin
                dm_ena   = 1'b1;
                dm_w     = 1'b1;
                dm_wdata = store_word;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (!err_q && is_load(op_q)) ? load_data : 32'h0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LW;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            word_q  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            err_q   <= err_d;
        end
    end

endmodule
